// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer: req/ack to instruction memory, valid/ready to decode.
// Optional feature macro: PC_MISALIGN_TRAP_EN (traps on misaligned redirect/flush targets).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        flush_en,
    input  logic [31:0] flush_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    input  logic        inst_ready,
    output logic        misalign
);

    localparam logic [31:0] STEP = PC_STEP[31:0];

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, HOLD = 3'd2, DRAIN = 3'd3, TRAP = 3'd4} state_t;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, HOLD = 3'd2, DRAIN = 3'd3} state_t;
`endif

    // Target as loaded into pc; without the trap feature low bits are simply cleared.
    function automatic logic [31:0] target_pc(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    function automatic logic is_misaligned(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
        return (t[1:0] != 2'b00);
`else
        return (t[1:0] != 2'b00) & 1'b0;
`endif
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] inst_pc4_q, inst_pc4_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        imem_req_q, imem_req_d;
    logic        inst_valid_q, inst_valid_d;
    logic        misalign_q, misalign_d;
    logic        accept_s;

    assign accept_s = inst_ready & ~stall;

    // Next-state, pc and held-instruction update; flush overrides every other event.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        misalign_d = misalign_q;
        if (flush_en) begin
            pc_d = target_pc(flush_pc);
            case (state_q)
                FETCH:   state_d = imem_ack ? FETCH : DRAIN;
                // An ack arriving with the flush retires the outstanding request, so refetch at once.
                DRAIN:   state_d = imem_ack ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
            if (is_misaligned(flush_pc)) begin
                state_d    = state_t'(3'd4);
                misalign_d = 1'b1;
            end else begin
                misalign_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        state_d   = HOLD;
                    end else begin
                        state_d = FETCH;
                    end
                end
                HOLD: begin
                    if (accept_s) begin
                        state_d = FETCH;
                        if (redirect_en) begin
                            pc_d = target_pc(redirect_pc);
                            if (is_misaligned(redirect_pc)) begin
                                state_d    = state_t'(3'd4);
                                misalign_d = 1'b1;
                            end else begin
                                misalign_d = misalign_q;
                            end
                        end else begin
                            pc_d = pc_q + STEP;
                        end
                    end else begin
                        state_d = HOLD;
                    end
                end
                DRAIN: state_d = imem_ack ? FETCH : DRAIN;
`ifdef PC_MISALIGN_TRAP_EN
                TRAP:  state_d = TRAP;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Output register inputs, decoded from the next state so every port comes straight off a flop.
    always_comb begin
        imem_req_d   = (state_d == FETCH) || (state_d == DRAIN);
        inst_valid_d = (state_d == HOLD);
        inst_pc4_d   = inst_pc_d + STEP;
        if (state_d == FETCH) begin
            imem_addr_d = pc_d;
        end else begin
            imem_addr_d = imem_addr_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= RESET_PC;
            inst_pc4_q   <= RESET_PC + STEP;
            imem_addr_q  <= RESET_PC;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_pc4_q   <= inst_pc4_d;
            imem_addr_q  <= imem_addr_d;
            imem_req_q   <= imem_req_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_pc4   = inst_pc4_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign   = misalign_q;
`else
    assign misalign   = misalign_q & 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed, table-driven bench for pc_fetch_unit; outputs are checked at the falling edge, inputs driven there too.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_en, flush_en, stall, imem_ack, inst_ready;
    logic [31:0] redirect_pc, flush_pc, imem_rdata;
    logic        imem_req, inst_valid, misalign;
    logic [31:0] imem_addr, inst, inst_pc, inst_pc4;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .flush_en(flush_en), .flush_pc(flush_pc), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
        .inst_ready(inst_ready), .misalign(misalign)
    );

    typedef struct {
        logic        fl;
        logic [31:0] fpc;
        logic        re;
        logic [31:0] rpc;
        logic        st;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[26];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic fl, input logic [31:0] fpc, input logic re, input logic [31:0] rpc,
                                input logic st, input logic ack, input logic [31:0] rdata, input logic rdy,
                                input logic e_req, input logic [31:0] e_addr, input logic e_val,
                                input logic [31:0] e_inst, input logic [31:0] e_ipc);
        vec_t v;
        v.fl = fl; v.fpc = fpc; v.re = re; v.rpc = rpc; v.st = st; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_inst = e_inst; v.e_ipc = e_ipc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr, input logic e_val,
                              input logic [31:0] e_inst, input logic [31:0] e_ipc, input logic e_mis);
        n_vec++;
        chk({tag, " imem_req"},   {31'd0, imem_req},   {31'd0, e_req});
        chk({tag, " imem_addr"},  imem_addr,           e_addr);
        chk({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, e_val});
        chk({tag, " inst"},       inst,                e_inst);
        chk({tag, " inst_pc"},    inst_pc,             e_ipc);
        chk({tag, " inst_pc4"},   inst_pc4,            e_ipc + 32'd4);
        chk({tag, " misalign"},   {31'd0, misalign},   {31'd0, e_mis});
    endtask

    task automatic drive(input vec_t v);
        flush_en = v.fl; flush_pc = v.fpc; redirect_en = v.re; redirect_pc = v.rpc;
        stall = v.st; imem_ack = v.ack; imem_rdata = v.rdata; inst_ready = v.rdy;
    endtask

    initial begin
        // Cycle-by-cycle: inputs for this cycle, and outputs expected during this cycle.
        //            fl    fpc           re    rpc           st    ack   rdata         rdy   req   addr          val   inst          ipc
        vecs[0]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0);
        vecs[1]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hA000_0000,1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0);
        vecs[2]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'hA000_0000,32'h0);
        vecs[3]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hA000_0001,1'b0, 1'b1, 32'h4,        1'b0, 32'hA000_0000,32'h0);
        vecs[4]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h4,        1'b1, 32'hA000_0001,32'h4);
        vecs[5]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hA000_0002,1'b0, 1'b1, 32'h8,        1'b0, 32'hA000_0001,32'h4);
        vecs[6]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h8,        1'b1, 32'hA000_0002,32'h8);
        vecs[7]  = mk(1'b0, 32'h0,        1'b1, 32'h300,      1'b0, 1'b1, 32'hA000_0003,1'b0, 1'b1, 32'hC,        1'b0, 32'hA000_0002,32'h8);
        vecs[8]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC,        1'b1, 32'hA000_0003,32'hC);
        vecs[9]  = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hA000_0004,1'b0, 1'b1, 32'h10,       1'b0, 32'hA000_0003,32'hC);
        vecs[10] = mk(1'b0, 32'h0,        1'b1, 32'h200,      1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h10,       1'b1, 32'hA000_0004,32'h10);
        vecs[11] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      1'b0, 32'hA000_0004,32'h10);
        vecs[12] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      1'b0, 32'hA000_0004,32'h10);
        vecs[13] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200,      1'b0, 32'hA000_0004,32'h10);
        vecs[14] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hB000_0000,1'b0, 1'b1, 32'h200,      1'b0, 32'hA000_0004,32'h10);
        vecs[15] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h200,      1'b1, 32'hB000_0000,32'h200);
        vecs[16] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h200,      1'b1, 32'hB000_0000,32'h200);
        vecs[17] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h200,      1'b1, 32'hB000_0000,32'h200);
        vecs[18] = mk(1'b1, 32'h80,       1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h204,      1'b0, 32'hB000_0000,32'h200);
        vecs[19] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h204,      1'b0, 32'hB000_0000,32'h200);
        vecs[20] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF,1'b0, 1'b1, 32'h204,      1'b0, 32'hB000_0000,32'h200);
        vecs[21] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hC000_0000,1'b0, 1'b1, 32'h80,       1'b0, 32'hB000_0000,32'h200);
        vecs[22] = mk(1'b1, 32'hFFFF_FFFC,1'b1, 32'h40,       1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h80,       1'b1, 32'hC000_0000,32'h80);
        vecs[23] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hD000_0000,1'b0, 1'b1, 32'hFFFF_FFFC,1'b0, 32'hC000_0000,32'h80);
        vecs[24] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hFFFF_FFFC,1'b1, 32'hD000_0000,32'hFFFF_FFFC);
        vecs[25] = mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hE000_0000,1'b0, 1'b1, 32'h0,        1'b0, 32'hD000_0000,32'hFFFF_FFFC);

        reset = 1'b1;
        drive(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
        repeat (3) @(negedge clk);
        check_outs("in_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 26; i++) begin
            check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_val,
                       vecs[i].e_inst, vecs[i].e_ipc, 1'b0);
            drive(vecs[i]);
            @(negedge clk);
        end

        // Misaligned redirect target 0x102 on an accept.
        check_outs("pre_mis", 1'b0, 32'h0, 1'b1, 32'hE000_0000, 32'h0, 1'b0);
        drive(mk(1'b0, 32'h0, 1'b1, 32'h102, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
        @(negedge clk);
`ifdef PC_MISALIGN_TRAP_EN
        check_outs("trap", 1'b0, 32'h0, 1'b0, 32'hE000_0000, 32'h0, 1'b1);
        drive(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
        @(negedge clk);
        check_outs("trap_sticky", 1'b0, 32'h0, 1'b0, 32'hE000_0000, 32'h0, 1'b1);
        drive(mk(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
        @(negedge clk);
        check_outs("trap_exit", 1'b1, 32'h100, 1'b0, 32'hE000_0000, 32'h0, 1'b0);
`else
        check_outs("mis_forced", 1'b1, 32'h100, 1'b0, 32'hE000_0000, 32'h0, 1'b0);
`endif
        // Reset while a fetch is outstanding abandons it.
        drive(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0));
        reset = 1'b1;
        @(negedge clk);
        check_outs("reset_mid", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_outs("after_reset_fetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
